video_out_dither: RTL and testbench
===================================

# video_out_dither

Parametrised palette-lookup and DAC output stage for the TSConf video path. It selects TV or VGA plex data and forms the palette address, including the hires nibble mode. It then reads a dual-port colour RAM (CRAM) that the CPU writes, and applies a global brightness fade driven by a frame-stepped state machine. Finally it truncates each colour component to the DAC width using ordered-dither PWM. It sits between the video renderers/scan-doubler and the board DAC pins, and replaces the fixed 5-bit-to-2-bit output stage.

## Interface
Parameters:
- CBITS, 5, colour component width in the CRAM word; CRAM word = 3*CBITS+1 bits, MSB is the mode bit
- DBITS, 2, DAC bits per component; legal range 1..CBITS-1; F = CBITS-DBITS fraction bits
- PALW, 8, CRAM address width; depth = 2^PALW; PALW ≥ 5
- FADE_FRAMES, 2, frame_stb pulses per fade step; ≥ 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- c3  in  1  TV pixel clock enable; the TV plex register loads only when c3=1
- vga_on  in  1  1 = VGA path, 0 = TV path
- tv_blank, vga_blank  in  1 each  blanking for each path
- vga_line  in  1  VGA line parity, used for the dither phase
- plex_sel  in  2  hires nibble select; [0] is used for VGA, [1] for TV
- tv_hires, vga_hires  in  1 each  hires mode for each path
- palsel  in  PALW-4  palette bank for hires
- vplex_in, vgaplex  in  PALW each  pixel index for each path
- cram_we  in  1  CRAM write strobe
- cram_addr  in  PALW  CRAM write address
- cram_data  in  3*CBITS+1  CRAM write data
- frame_stb  in  1  one-cycle pulse per frame
- fade_start  in  1  one-cycle pulse; loads fade_target
- fade_target  in  4  target brightness, 0..15
- fade_busy  out  1  fade in progress
- fade_done  out  1  one-cycle pulse when level reaches target
- fade_level  out  4  current brightness
- vred, vgrn, vblu  out  DBITS each  dithered DAC outputs
- vred_raw, vgrn_raw, vblu_raw  out  CBITS each  faded, blanked component before dithering
- vdac_mode  out  1  CRAM word MSB, unaffected by blanking

## Operation
- **Address formation**
  - plex = vga_on ? vgaplex : vplex_reg.
  - hires = the hires input of the selected path.
  - sel = the plex_sel bit of the selected path.
  - addr = hires ? {palsel, sel ? plex[3:0] : plex[7:4]} : plex.
  - blank = the blank input of the selected path.
- **CRAM**
  - Single clock domain; registered read with 1-cycle latency.
  - Write and read to the same address in the same cycle returns the old data (read-first).
  - Initial contents come from the existing CRAM .mif.
- **Fade scaling**
  - For each component c: s = (c*(L+1))>>4, where L = fade_level.
  - The product is CBITS+4 bits wide, so there is no overflow.
  - L=15 gives s=c, i.e. identity.
- **Blanking**
  - The blanked component is forced to 0 in the same stage as scaling.
  - vdac_mode passes through unblanked.
- **Dither**
  - Split s into coarse = s[CBITS-1:F] and frac = s[F-1:0].
  - Threshold t = bit-reverse of the F-bit phase P.
  - Output = coarse+1 when frac > t and coarse is not all-ones; otherwise output = coarse.
  - Over 2^F consecutive phases, coarse is incremented exactly frac times.
- **Phase**
  - ph is an F-bit counter, +1 every clk.
  - P = vga_on ? {vga_line, ph[F-2:0]} : ph. When F=1, P = vga_on ? vga_line : ph.
- **Fade FSM** (states IDLE, RUN)
  - Reset: IDLE, level=15, frame counter=0.
  - fade_start: load target, clear the frame counter, enter RUN. This applies in any state and restarts a fade that is already running.
  - If fade_start occurs with target == level: stay IDLE and pulse fade_done on the next cycle.
  - RUN: each frame_stb increments the frame counter. When the counter reaches FADE_FRAMES-1 on a strobe, clear it and step level by ±1 toward target.
  - When level equals target after a step: enter IDLE and pulse fade_done in the same cycle the state changes.
  - fade_start and frame_stb in the same cycle: fade_start wins and the strobe is ignored.
  - fade_busy = (state == RUN).

## Timing
- Pipeline stages:
  - Stage 0 (cycle N): address and blank sampled.
  - Stage 1 (N+1): CRAM q available; blank delayed 1.
  - Stage 2 (N+2): scaled/blanked raw registers.
  - Stage 3 (N+3): dithered vred/vgrn/vblu registers.
- Latencies:
  - *_raw and vdac_mode: 2 clk after the address.
  - DAC outputs: 3 clk after the address.
- The dither phase used at stage 3 is P as of cycle N+2.
- The TV plex register adds 1 enabled c3 cycle ahead of stage 0.
- Reset values:
  - All outputs 0, except fade_level=15.
  - Pipeline registers and ph = 0; vplex_reg = 0.
- Reset mid-fade: level returns to 15 and state to IDLE on the next clk; no fade_done pulse.
- A fade_level change takes effect on pixels whose stage-2 register loads in the next cycle.

## Test plan
- **CRAM write/read:** write 0x7FFF to address 0x12, then drive vga_on=1, vgaplex=0x12, blank=0 → raw = 31/31/31 at N+2, vred=vgrn=vblu=3 at N+3, vdac_mode=0. Write 0x8000 → vdac_mode=1, raw=0.
- **Hires address:** vga_hires=1, palsel=0xA, vgaplex=0x5C, plex_sel[0]=0 → address 0xA5; with plex_sel[0]=1 → address 0xAC.
- **Dither duty:** component 0b01011 (coarse 1, frac 3), F=3, vga_on=0 → over 8 consecutive clk, the output is 2 exactly 3 times and 1 five times. Component 31 → always 3, never wraps.
- **Blank alignment:** toggle vga_blank for 1 cycle at N with white pixels → raw=0 only at N+2, DAC=0 only at N+3.
- **Fade:** from level 15, fade_start with target 12, FADE_FRAMES=2 → level 14/13/12 after strobes 2/4/6; fade_done pulses once on the sixth strobe; fade_busy is high from the start until then. White component 31 at level 12 → raw 25.
- **Edge cases:**
  - fade_start with target 15 at level 15 → 1-cycle fade_done, fade_busy stays 0.
  - fade_start coinciding with frame_stb → no step on that strobe.
  - rst mid-fade → level 15, IDLE, all DAC outputs 0.

Source files
------------

// File: rtl/video_out_dither.sv
// video_out_dither
//   Palette lookup and DAC output stage for the TSConf video path.
//   Selects TV or VGA plex data and forms the palette address (including
//   the hires nibble mode), reads the CPU-written colour RAM, applies a
//   frame-stepped global brightness fade and truncates each component to
//   the DAC width with ordered-dither PWM.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   c3                       TV pixel clock enable (loads the TV plex register)
//   vga_on                   1 = VGA path, 0 = TV path
//   tv_blank, vga_blank      per-path blanking
//   vga_line                 VGA line parity (dither phase MSB in VGA mode)
//   plex_sel                 hires nibble select: [0] VGA, [1] TV
//   tv_hires, vga_hires      per-path hires mode
//   palsel                   palette bank used in hires mode
//   vplex_in, vgaplex        pixel index for the TV / VGA path
//   cram_we/addr/data        CRAM write port ({mode, R, G, B})
//   frame_stb                one-cycle pulse per frame
//   fade_start, fade_target  start a fade toward fade_target (0..15)
//   fade_busy, fade_done     fade in progress / one-cycle completion pulse
//   fade_level               current brightness (15 = full)
//   vred, vgrn, vblu         dithered DAC outputs (3 clk after address)
//   v*_raw, vdac_mode        faded, blanked components and mode bit (2 clk)
module video_out_dither #(
  parameter int CBITS       = 5,
  parameter int DBITS       = 2,
  parameter int PALW        = 8,
  parameter int FADE_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c3,
  input  logic                 vga_on,
  input  logic                 tv_blank,
  input  logic                 vga_blank,
  input  logic                 vga_line,
  input  logic [1:0]           plex_sel,
  input  logic                 tv_hires,
  input  logic                 vga_hires,
  input  logic [PALW-5:0]      palsel,
  input  logic [PALW-1:0]      vplex_in,
  input  logic [PALW-1:0]      vgaplex,
  input  logic                 cram_we,
  input  logic [PALW-1:0]      cram_addr,
  input  logic [3*CBITS:0]     cram_data,
  input  logic                 frame_stb,
  input  logic                 fade_start,
  input  logic [3:0]           fade_target,
  output logic                 fade_busy,
  output logic                 fade_done,
  output logic [3:0]           fade_level,
  output logic [DBITS-1:0]     vred,
  output logic [DBITS-1:0]     vgrn,
  output logic [DBITS-1:0]     vblu,
  output logic [CBITS-1:0]     vred_raw,
  output logic [CBITS-1:0]     vgrn_raw,
  output logic [CBITS-1:0]     vblu_raw,
  output logic                 vdac_mode
);

  localparam int F   = CBITS - DBITS;
  localparam int CW  = 3 * CBITS + 1;
  localparam int FCW = $clog2(FADE_FRAMES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  // ---------------- address formation ----------------
  logic [PALW-1:0] vplex_reg;
  logic [PALW-1:0] plex;
  logic [PALW-1:0] addr;
  logic            hires, sel, blank;

  always_ff @(posedge clk) begin
    if (rst)     vplex_reg <= '0;
    else if (c3) vplex_reg <= vplex_in;
  end

  always_comb begin
    plex  = vga_on ? vgaplex   : vplex_reg;
    hires = vga_on ? vga_hires : tv_hires;
    sel   = vga_on ? plex_sel[0] : plex_sel[1];
    blank = vga_on ? vga_blank : tv_blank;
    addr  = hires ? {palsel, (sel ? plex[3:0] : plex[7:4])} : plex;
  end

  // ---------------- CRAM (read-first, 1-cycle read) ----------------
  // Power-up contents are supplied by the memory initialisation flow.
  logic [CW-1:0] cram [0:(1<<PALW)-1];
  logic [CW-1:0] q;
  logic          blank_d1;

  always_ff @(posedge clk) begin
    if (cram_we) cram[cram_addr] <= cram_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      blank_d1 <= 1'b0;
    end else begin
      q        <= cram[addr];
      blank_d1 <= blank;
    end
  end

  // ---------------- fade scaling and blanking ----------------
  // Component index: 2 = red, 1 = green, 0 = blue.
  logic [4:0]                  lmul;
  logic [2:0][CBITS+4:0]       prod;
  logic [2:0][CBITS-1:0]       scaled;
  logic [2:0][CBITS-1:0]       raw;
  logic                        mode_r;

  assign lmul = {1'b0, fade_level} + 5'd1;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      prod[i]   = (CBITS+5)'(q[i*CBITS +: CBITS]) * (CBITS+5)'(lmul);
      scaled[i] = prod[i][CBITS+3:4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw    <= '0;
      mode_r <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++)
        raw[i] <= blank_d1 ? '0 : scaled[i];
      mode_r <= q[CW-1];
    end
  end

  // ---------------- ordered dither ----------------
  logic [F-1:0]              ph, phase, thr;
  logic [2:0][DBITS-1:0]     coarse, dith, dac;
  logic [2:0][F-1:0]         frac;

  always_ff @(posedge clk) begin
    if (rst) ph <= '0;
    else     ph <= ph + F'(1);
  end

  generate
    if (F == 1) begin : g_ph1
      assign phase = vga_on ? vga_line : ph;
    end else begin : g_phn
      assign phase = vga_on ? {vga_line, ph[F-2:0]} : ph;
    end
  endgenerate

  // Bit-reversed phase spreads the increments evenly over 2^F cycles.
  always_comb begin
    for (int unsigned i = 0; i < F; i++)
      thr[i] = phase[F-1-i];
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      coarse[i] = raw[i][CBITS-1:F];
      frac[i]   = raw[i][F-1:0];
      dith[i]   = (frac[i] > thr && coarse[i] != '1) ? coarse[i] + DBITS'(1)
                                                     : coarse[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dac <= '0;
    else     dac <= dith;
  end

  assign vred      = dac[2];
  assign vgrn      = dac[1];
  assign vblu      = dac[0];
  assign vred_raw  = raw[2];
  assign vgrn_raw  = raw[1];
  assign vblu_raw  = raw[0];
  assign vdac_mode = mode_r;

  // ---------------- fade FSM ----------------
  state_t         state;
  logic [3:0]     target;
  logic [FCW-1:0] fcnt;
  logic [3:0]     step_level;

  assign step_level = (target > fade_level) ? fade_level + 4'd1 : fade_level - 4'd1;
  assign fade_busy  = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fade_level <= 4'd15;
      target     <= '0;
      fcnt       <= '0;
      fade_done  <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      if (fade_start) begin
        // A start always wins over a coincident frame strobe.
        target <= fade_target;
        fcnt   <= '0;
        if (fade_target == fade_level) begin
          state     <= IDLE;
          fade_done <= 1'b1;
        end else begin
          state <= RUN;
        end
      end else if (state == RUN && frame_stb) begin
        if (fcnt == FCW'(FADE_FRAMES - 1)) begin
          fcnt       <= '0;
          fade_level <= step_level;
          if (step_level == target) begin
            state     <= IDLE;
            fade_done <= 1'b1;
          end
        end else begin
          fcnt <= fcnt + FCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_out_dither.sv
// Scoreboard bench for video_out_dither (default parameters: CBITS=5,
// DBITS=2, PALW=8, FADE_FRAMES=2). Stimulus pushes expected responses,
// a negedge monitor pops and compares them when they fall due.
module tb_video_out_dither;
  localparam int CB = 5;
  localparam int DB = 2;
  localparam int F  = CB - DB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c3 = 0, vga_on = 0, tv_blank = 0, vga_blank = 0, vga_line = 0;
  logic [1:0] plex_sel = '0;
  logic tv_hires = 0, vga_hires = 0;
  logic [3:0] palsel = '0;
  logic [7:0] vplex_in = '0, vgaplex = '0;
  logic cram_we = 0;
  logic [7:0] cram_addr = '0;
  logic [15:0] cram_data = '0;
  logic frame_stb = 0, fade_start = 0;
  logic [3:0] fade_target = '0;
  logic fade_busy, fade_done;
  logic [3:0] fade_level;
  logic [1:0] vred, vgrn, vblu;
  logic [4:0] vred_raw, vgrn_raw, vblu_raw;
  logic vdac_mode;

  video_out_dither dut (
    .clk(clk), .rst(rst), .c3(c3), .vga_on(vga_on), .tv_blank(tv_blank),
    .vga_blank(vga_blank), .vga_line(vga_line), .plex_sel(plex_sel),
    .tv_hires(tv_hires), .vga_hires(vga_hires), .palsel(palsel),
    .vplex_in(vplex_in), .vgaplex(vgaplex), .cram_we(cram_we),
    .cram_addr(cram_addr), .cram_data(cram_data), .frame_stb(frame_stb),
    .fade_start(fade_start), .fade_target(fade_target),
    .fade_busy(fade_busy), .fade_done(fade_done), .fade_level(fade_level),
    .vred(vred), .vgrn(vgrn), .vblu(vblu), .vred_raw(vred_raw),
    .vgrn_raw(vgrn_raw), .vblu_raw(vblu_raw), .vdac_mode(vdac_mode)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int r; int g; int b; int m; bit duty;} pix_t;
  typedef struct {int due; int r; int g; int b; bit duty;} dac_t;
  typedef struct {int due; int lvl; bit busy; bit done; bit zero;} fade_t;

  pix_t  pix_q[$];
  dac_t  dac_q[$];
  fade_t fade_q[$];

  int vectors = 0, errs = 0;
  int ec = 0, rst_ec = 0;
  int duty_seen = 0, duty_twos = 0;
  int cram_m[256];
  int tv_reg = 0;
  int mlevel = 15;

  // Edge counter; ph after edge k is (k - last reset edge) mod 2^F.
  always @(posedge clk) begin
    ec = ec + 1;
    if (rst) rst_ec = ec;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ec);
    end
  endtask

  function automatic int scale(int c, int l);
    return (c * (l + 1)) / 16;
  endfunction

  // Ordered-dither reference: threshold is the bit-reversed phase.
  function automatic int dith(int s, bit von, bit line, int ph);
    int p, t, co, fr;
    p  = von ? (line * (1 << (F-1)) + ph % (1 << (F-1))) : ph % (1 << F);
    t  = 0;
    for (int i = 0; i < F; i++)
      if (((p >> i) & 1) == 1) t = t | (1 << (F-1-i));
    co = s >> F;
    fr = s % (1 << F);
    return (fr > t && co < (1 << DB) - 1) ? co + 1 : co;
  endfunction

  // Monitor: compares every record that falls due at this negedge.
  always @(negedge clk) begin
    int e, ph;
    pix_t p;
    dac_t d;
    fade_t f;
    e = ec;
    while (pix_q.size() > 0 && pix_q[0].due <= e) begin
      p = pix_q.pop_front();
      chk("vred_raw", vred_raw, p.r);
      chk("vgrn_raw", vgrn_raw, p.g);
      chk("vblu_raw", vblu_raw, p.b);
      chk("vdac_mode", vdac_mode, p.m);
      dac_q.push_back('{due: e + 1, r: p.r, g: p.g, b: p.b, duty: p.duty});
    end
    while (dac_q.size() > 0 && dac_q[0].due <= e) begin
      d  = dac_q.pop_front();
      // Inputs still hold the previous window's values (the stage-3 phase).
      ph = ((e - 1) - rst_ec) & ((1 << F) - 1);
      chk("vred", vred, dith(d.r, vga_on, vga_line, ph));
      chk("vgrn", vgrn, dith(d.g, vga_on, vga_line, ph));
      chk("vblu", vblu, dith(d.b, vga_on, vga_line, ph));
      if (d.duty) begin
        duty_seen++;
        if (vred == 2'd2) duty_twos++;
      end
    end
    while (fade_q.size() > 0 && fade_q[0].due <= e) begin
      f = fade_q.pop_front();
      chk("fade_level", fade_level, f.lvl);
      chk("fade_busy", fade_busy, f.busy);
      chk("fade_done", fade_done, f.done);
      if (f.zero) begin
        chk("rst_vred", vred, 0);
        chk("rst_vgrn", vgrn, 0);
        chk("rst_vblu", vblu, 0);
        chk("rst_raw", {vred_raw, vgrn_raw, vblu_raw}, 0);
        chk("rst_mode", vdac_mode, 0);
      end
    end
  end

  task automatic next_win();
    @(negedge clk);
    #1;
  endtask

  task automatic ctl(bit fs, bit st, int tgt);
    next_win();
    cram_we = 0; c3 = 0;
    fade_start = fs; frame_stb = st; fade_target = 4'(tgt);
  endtask

  task automatic wr(int a, int d);
    ctl(0, 0, 0);
    cram_we = 1; cram_addr = 8'(a); cram_data = 16'(d);
    cram_m[a] = d;
  endtask

  task automatic pushf(int due, int lvl, bit busy, bit done, bit zero);
    fade_q.push_back('{due: due, lvl: lvl, busy: busy, done: done, zero: zero});
  endtask

  task automatic pix(bit von, int vgap, int tvp, bit c3v, bit vh, bit th,
                     bit [1:0] ps, int pal, bit bl, bit we, int wa, int wd,
                     bit duty);
    int a, word, plex, w, r, g, b;
    bit h, sel;
    ctl(0, 0, 0);
    w = ec;
    vga_on = von; vgaplex = 8'(vgap); vplex_in = 8'(tvp); c3 = c3v;
    vga_hires = vh; tv_hires = th; plex_sel = ps; palsel = 4'(pal);
    vga_line = 1'($urandom % 2);
    if (von) begin vga_blank = bl; tv_blank = 1'($urandom % 2); end
    else     begin tv_blank = bl;  vga_blank = 1'($urandom % 2); end
    cram_we = we; cram_addr = 8'(wa); cram_data = 16'(wd);
    plex = von ? vgap : tv_reg;
    h    = von ? vh : th;
    sel  = von ? ps[0] : ps[1];
    a    = h ? pal * 16 + (sel ? plex % 16 : (plex / 16) % 16) : plex;
    word = cram_m[a];
    r = bl ? 0 : scale((word >> 10) & 31, mlevel);
    g = bl ? 0 : scale((word >> 5) & 31, mlevel);
    b = bl ? 0 : scale(word & 31, mlevel);
    pix_q.push_back('{due: w + 2, r: r, g: g, b: b, m: (word >> 15) & 1, duty: duty});
    if (we) cram_m[wa] = wd;
    if (c3v) tv_reg = tvp;
  endtask

  task automatic randpix();
    pix(1'($urandom % 2), $urandom % 256, $urandom % 256, 1'($urandom % 2),
        ($urandom % 4) == 0, ($urandom % 4) == 0, 2'($urandom), $urandom % 16,
        ($urandom % 5) == 0, 1'($urandom % 2), $urandom % 256,
        $urandom % 65536, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (pix_q.size() + dac_q.size() + fade_q.size()) > 0; i++)
      ctl(0, 0, 0);
    if ((pix_q.size() + dac_q.size() + fade_q.size()) > 0) begin
      vectors++; errs++;
      $display("FAIL drain: %0d records outstanding, expected 0",
               pix_q.size() + dac_q.size() + fade_q.size());
      pix_q.delete(); dac_q.delete(); fade_q.delete();
    end
  endtask

  initial begin
    // Reset state
    ctl(0, 0, 0);
    ctl(0, 0, 0);
    pushf(ec + 1, 15, 0, 0, 1);
    ctl(0, 0, 0);
    rst = 0;
    tv_reg = 0;

    for (int i = 0; i < 256; i++) wr(i, $urandom % 65536);

    // Start with target equal to current level
    ctl(1, 0, 15);
    pushf(ec + 1, 15, 0, 1, 0);
    pushf(ec + 2, 15, 0, 0, 0);
    ctl(0, 0, 0);

    // CRAM white / mode bit
    wr(8'h12, 16'h7FFF);
    pix(1, 8'h12, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    wr(8'h12, 16'h8000);
    pix(1, 8'h12, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Hires address: bank 0xA, nibble chosen by plex_sel[0]
    wr(8'hA5, 16'h1234);
    wr(8'hAC, 16'h4321);
    pix(1, 8'h5C, 0, 0, 1, 0, 2'b10, 4'hA, 0, 0, 0, 0, 0);
    pix(1, 8'h5C, 0, 0, 1, 0, 2'b01, 4'hA, 0, 0, 0, 0, 0);

    // One-cycle blank on white
    wr(32, 16'h7FFF);
    pix(1, 32, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    pix(1, 32, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    pix(1, 32, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Dither duty on the TV path: component 0b01011
    wr(48, (11 << 10) | (11 << 5) | 11);
    pix(0, 0, 48, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) pix(0, 0, 48, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) pix(0, 0, 48, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) randpix();
    drain();
    chk("duty_samples", duty_seen, 8);
    chk("duty_twos", duty_twos, 3);

    // Fade 15 -> 12; the strobe coinciding with the start is ignored
    ctl(1, 1, 12);
    pushf(ec + 1, 15, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      ctl(0, 0, 12);
      ctl(0, 1, 12);
      pushf(ec + 1, 15 - i / 2, i < 6, i == 6, 0);
      pushf(ec + 2, 15 - i / 2, i < 6, 1'b0, 0);
    end
    ctl(0, 0, 12);
    drain();

    mlevel = 12;
    wr(64, 16'h7FFF);
    pix(1, 64, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) randpix();
    drain();

    // Reset in the middle of a fade toward 0
    ctl(1, 0, 0);
    pushf(ec + 1, 12, 1, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      ctl(0, 0, 0);
      ctl(0, 1, 0);
      pushf(ec + 1, 12 - i / 2, 1, 0, 0);
    end
    ctl(0, 0, 0);
    rst = 1;
    pushf(ec + 1, 15, 0, 0, 1);
    ctl(0, 1, 0);
    rst = 0;
    pushf(ec + 1, 15, 0, 0, 1);
    tv_reg = 0;
    mlevel = 15;
    ctl(0, 1, 0);
    pushf(ec + 1, 15, 0, 0, 0);

    for (int i = 0; i < 100; i++) randpix();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
